code_conv_fifo: RTL and testbench

//   Parametrised, clocked code converter with a result buffer: the next generation of the
//   4-bit combinational converter. Each accepted word is converted in one of four modes
//   (bin->gray, gray->bin, BCD->XS3, XS3->BCD), flagged if it holds illegal digits, and

---
 rtl/code_conv_fifo.sv | 120 ++++++++++++
 tb/tb_code_conv_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/code_conv_fifo.sv
// Clocked 4-mode code converter (bin/gray, BCD/XS3) feeding a DEPTH-entry result FIFO.
// Optional build macro CONV_ERRCNT_EN adds a saturating count of illegal accepted words.
module code_conv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NIB = WIDTH / 4;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_err;

  logic [WIDTH-1:0] conv_data;
  logic             conv_err;
  logic [3:0]       nib;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Gray->bin uses the prefix-XOR form: b[i] = XOR of g[WIDTH-1:i].
  always_comb begin
    conv_data = '0;
    conv_err  = 1'b0;
    nib       = 4'h0;
    case (in_mode)
      2'b00: conv_data = in_data ^ (in_data >> 1);
      2'b01: begin
        for (int i = 0; i < WIDTH; i++) begin
          conv_data[i] = ^(in_data >> i);
        end
      end
      2'b10: begin
        for (int n = 0; n < NIB; n++) begin
          nib = in_data[4*n +: 4];
          if (nib > 4'd9) begin
            conv_data[4*n +: 4] = 4'hF;
            conv_err            = 1'b1;
          end else begin
            conv_data[4*n +: 4] = nib + 4'd3;
          end
        end
      end
      default: begin
        for (int n = 0; n < NIB; n++) begin
          nib = in_data[4*n +: 4];
          if ((nib < 4'd3) || (nib > 4'd12)) begin
            conv_data[4*n +: 4] = 4'hF;
            conv_err            = 1'b1;
          end else begin
            conv_data[4*n +: 4] = nib - 4'd3;
          end
        end
      end
    endcase
  end

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_err <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr[AW-1:0]] <= conv_data;
        mem_err[wr_ptr[AW-1:0]]  <= conv_err;
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign out_data = mem_data[rd_ptr[AW-1:0]];
  assign out_err  = mem_err[rd_ptr[AW-1:0]];

`ifdef CONV_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counted at accept so words discarded by a later reset are still included until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (push && conv_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_code_conv_fifo.sv
// Directed bench for code_conv_fifo (WIDTH=8, DEPTH=4): conversion table plus FIFO/reset sequences.
module tb_code_conv_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [14];

  code_conv_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [1:0] m, input logic [7:0] d);
    int t;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: in_ready stuck at %0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 8'h0B, 8'h0E, 1'b0};
    vecs[1]  = '{2'b01, 8'h0E, 8'h0B, 1'b0};
    vecs[2]  = '{2'b00, 8'hFF, 8'h80, 1'b0};
    vecs[3]  = '{2'b01, 8'h80, 8'hFF, 1'b0};
    vecs[4]  = '{2'b10, 8'h59, 8'h8C, 1'b0};
    vecs[5]  = '{2'b10, 8'h5A, 8'h8F, 1'b1};
    vecs[6]  = '{2'b11, 8'h8C, 8'h59, 1'b0};
    vecs[7]  = '{2'b11, 8'h21, 8'hFF, 1'b1};
    vecs[8]  = '{2'b10, 8'h00, 8'h33, 1'b0};
    vecs[9]  = '{2'b10, 8'h99, 8'hCC, 1'b0};
    vecs[10] = '{2'b10, 8'hA0, 8'hF3, 1'b1};
    vecs[11] = '{2'b11, 8'h3C, 8'h09, 1'b0};
    vecs[12] = '{2'b11, 8'hD3, 8'hF0, 1'b1};
    vecs[13] = '{2'b01, 8'h5A, 8'h6C, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_err_cnt", err_cnt, 0);

    // Conversion table: each word visible right after its accept edge, gone after the pop edge.
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      push_word(vecs[k].mode, vecs[k].data);
      check($sformatf("vec%0d_valid", k), out_valid, 1);
      check($sformatf("vec%0d_data", k), out_data, vecs[k].exp_data);
      check($sformatf("vec%0d_err", k), out_err, vecs[k].exp_err);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_popped", k), out_valid, 0);
    end
`ifdef CONV_ERRCNT_EN
    check("errcnt_after_table", err_cnt, 4);
`else
    check("errcnt_after_table", err_cnt, 0);
`endif

    // Fill and backpressure.
    out_ready = 1'b0;
    push_word(2'b00, 8'h01);
    push_word(2'b00, 8'h02);
    push_word(2'b00, 8'h03);
    push_word(2'b00, 8'h04);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = 8'h05;
    repeat (2) @(posedge clk);
    #1;
    check("held_in_ready", in_ready, 0);
    check("held_head", out_data, 8'h01);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("full_pop_no_push", in_ready, 1);
    check("drain0", out_data, 8'h03);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("drain1", out_data, 8'h02);
    @(posedge clk);
    #1;
    check("drain2", out_data, 8'h06);
    @(posedge clk);
    #1;
    check("drain3_valid", out_valid, 1);
    check("drain3", out_data, 8'h07);
    @(posedge clk);
    #1;
    check("drained_empty", out_valid, 0);

    // Mid-operation reset with a word presented during rst.
    out_ready = 1'b0;
    push_word(2'b00, 8'h10);
    push_word(2'b00, 8'h20);
    push_word(2'b10, 8'hAB);
    check("queued_valid", out_valid, 1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = 8'h77;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_err_cnt", err_cnt, 0);
    out_ready = 1'b1;
    push_word(2'b00, 8'h0B);
    check("post_rst_head", out_data, 8'h0E);
    @(posedge clk);
    #1;
    check("post_rst_empty", out_valid, 0);

    // Illegal-word counting across saturation.
    in_valid = 1'b1;
    in_mode  = 2'b10;
    in_data  = 8'hAA;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef CONV_ERRCNT_EN
    check("errcnt_saturated", err_cnt, 8'hFF);
`else
    check("errcnt_disabled", err_cnt, 8'h00);
`endif
    check("errcnt_head_err", out_err, 1);
    check("errcnt_head_data", out_data, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
